somador_pipe_param: RTL and testbench
=====================================

// Module: somador_pipe_param
// PURPOSE
//  Parametrised, pipelined WIDTH-bit adder/subtractor with valid/ready handshake on both sides.
//  Generalises the 4-bit ripple adder: configurable width, configurable pipeline depth,
//  run-time add/sub mode, and carry/overflow/zero flags.
//  Sits between an operand source and a result sink in the datapath; one operation/cycle sustained.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; must be >= 2 and a multiple of STAGES
//  STAGES  2  pipeline stages; each stage adds one WIDTH/STAGES-bit chunk, LSB chunk first
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: add, 1: subtract
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  out_valid  out  1      result valid
//  out_ready  in   1      sink accepts result this cycle
//  s          out  WIDTH  result
//  cout       out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      two's-complement signed overflow
//  zero       out  1      s == 0
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset synchronous, active-high (rst).
//  Arithmetic: Beff = sub ? ~b : b; c0 = cin ^ sub; {cout,s} = a + Beff + c0, computed at WIDTH+1 bits.
//   Add: a+b+cin. Sub: a-b-cin.
//   ovf = (a[MSB] == Beff[MSB]) && (s[MSB] != a[MSB]); zero = ~|s.
//  Pipeline: stage k (0..STAGES-1) adds chunk k using the carry registered from stage k-1.
//   Unprocessed upper chunks of a/Beff, finished lower chunks of s, and the valid bit travel with the op.
//   Last stage register drives s/cout/ovf/zero/out_valid directly; no combinational path from a/b to outputs.
//  Latency: op accepted on edge E (in_valid && in_ready) -> out_valid=1 after edge E+STAGES-1.
//   STAGES=1: result is visible the cycle after acceptance.
//  Handshake:
//   - advance = !out_valid || out_ready; in_ready = advance (pure function of out_valid/out_ready).
//   - On advance, every stage shifts one place; bubbles (valid=0) shift like data.
//   - When !advance, all stages hold; s/cout/ovf/zero stay stable while out_valid && !out_ready.
//   - in_valid while !in_ready: operands ignored; source holds them.
//   - Result retires on out_valid && out_ready. Results come out in acceptance order, never duplicated or dropped.
//  Throughput: with out_ready held at 1, accepts one op/cycle and emits one result/cycle after fill.
//  Reset: all stage valid bits clear; out_valid=0, s=0, cout=0, ovf=0, zero=0.
//   in_ready=1 from the first cycle after reset.
//   Reset mid-operation discards all in-flight ops; none is emitted afterwards.
//   Reset overrides simultaneous in_valid; that op is not accepted.
//  Wrap-around: results are modulo 2^WIDTH; cout/ovf report the wrap, and no saturation is applied.
//  Unused data in bubble stages is don't-care; only out_valid qualifies the outputs.
// TESTING  (WIDTH=8, STAGES=2 unless noted)
//  T1 add 0xFF+0x01 cin=0, out_ready=1 -> s=0x00 cout=1 ovf=0 zero=1; out_valid after 2nd edge counting accept edge.
//  T2 add 0x7F+0x01 -> s=0x80 cout=0 ovf=1 zero=0; add 0x0F+0x01 -> s=0x10 (carry crosses chunk boundary).
//  T3 sub 0x05-0x07 cin=0 -> s=0xFE cout=0 ovf=0; sub 0x80-0x01 -> s=0x7F cout=1 ovf=1; sub 0x10-0x0F cin=1 -> s=0x00 zero=1.
//  T4 stream 0x01+0x01, 0x02+0x02, 0x03+0x03 back-to-back; out_ready=0 for 3 cycles once first result is valid
//     -> s held at 0x02, in_ready=0, nothing lost; release -> 0x02, 0x04, 0x06 in order, one per cycle.
//  T5 two ops in flight, rst=1 for one cycle -> out_valid=0 and outputs zero next cycle; no stale result emitted;
//     in_ready=1 the following cycle.
//  T6 random a/b/sub/cin with random in_valid/out_ready for WIDTH=16/STAGES=4 and WIDTH=8/STAGES=1
//     -> scoreboard matches the reference model {cout,s}, ovf and zero for every retired op.

Source files
------------

// File: rtl/somador_pipe_param.sv
// Pipelined WIDTH-bit adder/subtractor: one WIDTH/STAGES-bit chunk per stage, LSB chunk first,
// with a valid/ready handshake on both sides and carry/overflow/zero flags on the result.
module somador_pipe_param #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per stage: valid bit, carry into the next chunk, operands (upper chunks still pending)
    // and the partial sum (lower chunks already finished).
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              advance;
    logic [WIDTH:0]    step;

    // Adds chunk k of aa/bb with carry cc and splices it into ss; returns {carry_out, new_sum}.
    function automatic logic [WIDTH:0] add_chunk(input logic [WIDTH-1:0] aa,
                                                 input logic [WIDTH-1:0] bb,
                                                 input logic [WIDTH-1:0] ss,
                                                 input logic             cc,
                                                 input int               k);
        logic [CW:0]      sum;
        logic [WIDTH-1:0] sn;
        sum = {1'b0, aa[k*CW +: CW]} + {1'b0, bb[k*CW +: CW]} + {{CW{1'b0}}, cc};
        sn  = ss;
        sn[k*CW +: CW] = sum[CW-1:0];
        return {sum[CW], sn};
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        v_d    = v_q;
        c_d    = c_q;
        a_d    = a_q;
        b_d    = b_q;
        s_d    = s_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        step   = '0;

        advance = !v_q[LAST] || out_ready;

        if (advance) begin
            // Stage 0 takes the operands straight from the port; subtraction is a + ~b + 1.
            a_d[0] = a;
            b_d[0] = sub ? ~b : b;
            step   = add_chunk(a, sub ? ~b : b, '0, cin ^ sub, 0);
            s_d[0] = step[WIDTH-1:0];
            c_d[0] = step[WIDTH];
            v_d[0] = in_valid;

            for (int k = 1; k < STAGES; k++) begin
                a_d[k] = a_q[k-1];
                b_d[k] = b_q[k-1];
                step   = add_chunk(a_q[k-1], b_q[k-1], s_q[k-1], c_q[k-1], k);
                s_d[k] = step[WIDTH-1:0];
                c_d[k] = step[WIDTH];
                v_d[k] = v_q[k-1];
            end

            ovf_d  = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1]) &&
                     (s_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
            zero_d = ~|s_d[LAST];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            v_q    <= v_d;
            c_q    <= c_d;
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = v_q[LAST];
    assign s         = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_somador_pipe_param.sv
// Directed checks on the 8-bit/2-stage adder plus randomized scoreboard runs on
// 16-bit/4-stage and 8-bit/1-stage instances.
module tb_somador_pipe_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-bit / 2-stage instance (directed)
    logic       iv8, ir8, sb8, ci8, ov8, or8, co8, of8, z8;
    logic [7:0] a8, b8, s8;
    somador_pipe_param #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sb8),
        .cin(ci8), .out_valid(ov8), .out_ready(or8), .s(s8), .cout(co8), .ovf(of8), .zero(z8));

    // 16-bit / 4-stage instance (random)
    logic        iv16, ir16, sb16, ci16, ov16, or16, co16, of16, z16;
    logic [15:0] a16, b16, s16;
    somador_pipe_param #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .sub(sb16),
        .cin(ci16), .out_valid(ov16), .out_ready(or16), .s(s16), .cout(co16), .ovf(of16), .zero(z16));

    // 8-bit / 1-stage instance (random)
    logic       iv1, ir1, sb1, ci1, ov1, or1, co1, of1, z1;
    logic [7:0] a1, b1, s1;
    somador_pipe_param #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .sub(sb1),
        .cin(ci1), .out_valid(ov1), .out_ready(or1), .s(s1), .cout(co1), .ovf(of1), .zero(z1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {zero, ovf, cout, s[15:0]} for a w-bit operation.
    function automatic logic [18:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic sub, input logic cin);
        logic [31:0] mask, beff, t, sum;
        mask = (32'd1 << w) - 32'd1;
        beff = (sub ? ~{16'h0, b} : {16'h0, b}) & mask;
        t    = {16'h0, a} + beff + {31'h0, cin ^ sub};
        sum  = t & mask;
        return {sum == 32'd0, (a[w-1] == beff[w-1]) && (sum[w-1] != a[w-1]), t[w], sum[15:0]};
    endfunction

    // Single operation through the 2-stage instance with the sink always ready.
    task automatic op8(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                       input logic sb, input logic ci, input logic [7:0] es,
                       input logic ec, input logic eo, input logic ez);
        iv8 = 1'b1; a8 = aa; b8 = bb; sb8 = sb; ci8 = ci; or8 = 1'b1;
        #1 check({tag, "_in_ready"}, 32'(ir8), 32'd1);
        tick();
        iv8 = 1'b0;
        check({tag, "_not_yet_valid"}, 32'(ov8), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(ov8), 32'd1);
        check({tag, "_s"}, 32'(s8), 32'(es));
        check({tag, "_cout"}, 32'(co8), 32'(ec));
        check({tag, "_ovf"}, 32'(of8), 32'(eo));
        check({tag, "_zero"}, 32'(z8), 32'(ez));
        tick();
        check({tag, "_retired"}, 32'(ov8), 32'd0);
    endtask

    logic [18:0] q16[$];
    logic [18:0] q1[$];
    logic [18:0] e;
    logic        pend16, pend1, acc16, acc1;

    initial begin
        rst = 1'b1;
        iv8 = 0; a8 = 0; b8 = 0; sb8 = 0; ci8 = 0; or8 = 0;
        iv16 = 0; a16 = 0; b16 = 0; sb16 = 0; ci16 = 0; or16 = 0;
        iv1 = 0; a1 = 0; b1 = 0; sb1 = 0; ci1 = 0; or1 = 0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(ov8), 32'd0);
        check("rst_s", 32'(s8), 32'd0);
        check("rst_flags", {29'd0, co8, of8, z8}, 32'd0);
        check("rst_in_ready", 32'(ir8), 32'd1);

        // T1..T3: single operations with hand-computed results
        op8("t1_ff_plus_01", 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1);
        op8("t2_7f_plus_01", 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 0);
        op8("t2_0f_plus_01", 8'h0F, 8'h01, 0, 0, 8'h10, 0, 0, 0);
        op8("t3_05_minus_07", 8'h05, 8'h07, 1, 0, 8'hFE, 0, 0, 0);
        op8("t3_80_minus_01", 8'h80, 8'h01, 1, 0, 8'h7F, 1, 1, 0);
        op8("t3_10_minus_0f_b", 8'h10, 8'h0F, 1, 1, 8'h00, 1, 0, 1);

        // T4: back-to-back stream with a 3-cycle sink stall
        or8 = 1'b1; sb8 = 0; ci8 = 0;
        iv8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
        tick();
        check("t4_fill", 32'(ov8), 32'd0);
        a8 = 8'h02; b8 = 8'h02;
        tick();
        check("t4_first_valid", 32'(ov8), 32'd1);
        check("t4_first_s", 32'(s8), 32'h02);
        a8 = 8'h03; b8 = 8'h03; or8 = 1'b0;
        #1 check("t4_stall_in_ready", 32'(ir8), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_valid", 32'(ov8), 32'd1);
            check("t4_hold_s", 32'(s8), 32'h02);
            check("t4_hold_in_ready", 32'(ir8), 32'd0);
        end
        or8 = 1'b1;
        #1 check("t4_release_in_ready", 32'(ir8), 32'd1);
        tick();
        iv8 = 1'b0;
        check("t4_second_valid", 32'(ov8), 32'd1);
        check("t4_second_s", 32'(s8), 32'h04);
        tick();
        check("t4_third_valid", 32'(ov8), 32'd1);
        check("t4_third_s", 32'(s8), 32'h06);
        tick();
        check("t4_drained", 32'(ov8), 32'd0);

        // T5: reset with two ops in flight and a third offered on the reset edge
        iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22; or8 = 1'b1;
        tick();
        a8 = 8'h33; b8 = 8'h44;
        tick();
        a8 = 8'h55; b8 = 8'h66; or8 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; iv8 = 1'b0; or8 = 1'b1;
        check("t5_out_valid", 32'(ov8), 32'd0);
        check("t5_s", 32'(s8), 32'd0);
        check("t5_flags", {29'd0, co8, of8, z8}, 32'd0);
        #1 check("t5_in_ready", 32'(ir8), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_stale", 32'(ov8), 32'd0);
        end

        // T6: random traffic on the 16/4 and 8/1 instances against the reference model
        pend16 = 1'b0; pend1 = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            or16 = 1'($urandom_range(0, 3) != 0);
            or1  = 1'($urandom_range(0, 3) != 0);
            if (!pend16) begin
                iv16 = 1'($urandom_range(0, 1));
                a16 = 16'($urandom); b16 = 16'($urandom);
                sb16 = 1'($urandom_range(0, 1)); ci16 = 1'($urandom_range(0, 1));
                pend16 = iv16;
            end
            if (!pend1) begin
                iv1 = 1'($urandom_range(0, 1));
                a1 = 8'($urandom); b1 = 8'($urandom);
                sb1 = 1'($urandom_range(0, 1)); ci1 = 1'($urandom_range(0, 1));
                pend1 = iv1;
            end
            #1;
            acc16 = iv16 && ir16;
            acc1  = iv1 && ir1;
            if (ov16 && or16) begin
                check("t6_16_sb_nonempty", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("t6_16_s", 32'(s16), 32'(e[15:0]));
                    check("t6_16_cout", 32'(co16), 32'(e[16]));
                    check("t6_16_ovf", 32'(of16), 32'(e[17]));
                    check("t6_16_zero", 32'(z16), 32'(e[18]));
                end
            end
            if (ov1 && or1) begin
                check("t6_8_sb_nonempty", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check("t6_8_s", 32'(s1), 32'(e[7:0]));
                    check("t6_8_cout", 32'(co1), 32'(e[16]));
                    check("t6_8_ovf", 32'(of1), 32'(e[17]));
                    check("t6_8_zero", 32'(z1), 32'(e[18]));
                end
            end
            if (acc16) q16.push_back(ref_op(16, a16, b16, sb16, ci16));
            if (acc1)  q1.push_back(ref_op(8, {8'h00, a1}, {8'h00, b1}, sb1, ci1));
            tick();
            if (acc16) pend16 = 1'b0;
            if (acc1)  pend1 = 1'b0;
        end

        // Drain: stop offering, keep the sinks ready, retire everything in flight
        iv16 = 1'b0; iv1 = 1'b0; or16 = 1'b1; or1 = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            if (ov16) begin
                check("drain_16_sb_nonempty", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("drain_16_s", 32'(s16), 32'(e[15:0]));
                    check("drain_16_flags", {29'd0, z16, of16, co16}, {29'd0, e[18:16]});
                end
            end
            if (ov1) begin
                check("drain_8_sb_nonempty", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check("drain_8_s", 32'(s1), 32'(e[7:0]));
                    check("drain_8_flags", {29'd0, z1, of1, co1}, {29'd0, e[18:16]});
                end
            end
            tick();
        end
        check("t6_16_all_retired", 32'(q16.size()), 32'd0);
        check("t6_8_all_retired", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
